up_wishbone_classic_master: RTL

Bridges the uP request/acknowledge interface onto a Wishbone Classic master port, and is the initiator counterpart of our Wishbone Classic slave-to-uP block. A uP-side requester issues single read or write requests. The block runs one Wishbone Classic cycle per request with `CTI_CLASSIC` and linear `BTE`, then returns a one-cycle acknowledge with read data or an error flag. A bus-timeout counter guarantees that every request terminates.

---
 rtl/up_wishbone_classic_master_pkg.sv | 34 +++
 rtl/up_wishbone_classic_master_if.sv | 43 ++++
 rtl/up_wishbone_classic_master_wb_timeout_counter.sv | 46 ++++
 rtl/up_wishbone_classic_master.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/up_wishbone_classic_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : up_wishbone_classic_master_pkg
// Description : Shared types and constants for the uP-to-Wishbone Classic
//               master bridge. Holds the Wishbone cycle-type and burst-type
//               encodings, the bridge state encoding and a helper that sizes
//               the bus-timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package up_wishbone_classic_master_pkg;

    // Wishbone registered-feedback encodings driven by this master
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Bridge sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Width of a counter that must reach 'limit'. A disabled timeout (0)
    // still gets a 1-bit counter so no zero-width vector is ever declared.
    function automatic int unsigned cnt_width(input int unsigned limit);
        if (limit < 1) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/up_wishbone_classic_master_if.sv
`default_nettype none
// ============================================================================
// Module      : up_wishbone_classic_master_if
// Description : Wishbone Classic bus bundle between the bridge (master
//               modport) and a slave (slave modport).
//   m_wb_cyc/stb/we   master -> slave   cycle, strobe, write enable
//   m_wb_addr         master -> slave   ADDRESS_WIDTH address
//   m_wb_data_o       master -> slave   BUS_WIDTH*8 write data
//   m_wb_sel          master -> slave   BUS_WIDTH byte selects
//   m_wb_bte/cti      master -> slave   burst / cycle type
//   m_wb_ack/err      slave  -> master  termination
//   m_wb_data_i       slave  -> master  BUS_WIDTH*8 read data
// Revision    : 1.0 - initial release
// ============================================================================
interface up_wishbone_classic_master_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 4
);
    logic                       m_wb_cyc;
    logic                       m_wb_stb;
    logic                       m_wb_we;
    logic [ADDRESS_WIDTH-1:0]   m_wb_addr;
    logic [BUS_WIDTH*8-1:0]     m_wb_data_o;
    logic [BUS_WIDTH-1:0]       m_wb_sel;
    logic [1:0]                 m_wb_bte;
    logic [2:0]                 m_wb_cti;
    logic                       m_wb_ack;
    logic                       m_wb_err;
    logic [BUS_WIDTH*8-1:0]     m_wb_data_i;

    modport master (
        output m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o,
               m_wb_sel, m_wb_bte, m_wb_cti,
        input  m_wb_ack, m_wb_err, m_wb_data_i
    );

    modport slave (
        input  m_wb_cyc, m_wb_stb, m_wb_we, m_wb_addr, m_wb_data_o,
               m_wb_sel, m_wb_bte, m_wb_cti,
        output m_wb_ack, m_wb_err, m_wb_data_i
    );
endinterface
`default_nettype wire

// File: rtl/up_wishbone_classic_master_wb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Clear/enable/saturate cycle counter with an 'expired' flag
//               raised once the count equals TIMEOUT. TIMEOUT = 0 disables
//               the flag permanently.
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   clr_i      in   synchronous clear (dominates enable)
//   en_i       in   count enable
//   expired_o  out  count has reached TIMEOUT
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter
    import up_wishbone_classic_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      expired_o
);

    localparam int unsigned      CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;

    // Holds at CNT_MAX rather than wrapping, so a stalled cycle can never
    // miss its expiry by rolling the counter over.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired_o = (TIMEOUT != 0) && (count_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/up_wishbone_classic_master.sv
`default_nettype none
// ============================================================================
// Module      : up_wishbone_classic_master
// Description : Bridges single uP read/write requests onto a Wishbone
//               Classic master port. One classic cycle per request, then a
//               one-cycle uP acknowledge carrying read data or an error flag.
//               A bus timeout guarantees every request terminates.
//   clk                in   clock
//   rstn               in   asynchronous active-low reset
//   up_rreq/up_raddr   in   read request (level) and address
//   up_rack/up_rdata   out  read acknowledge pulse and data
//   up_wreq/up_waddr   in   write request (level) and address
//   up_wdata           in   write data
//   up_wack            out  write acknowledge pulse
//   up_err             out  qualifies the current acknowledge as failed
//   wb                 if   Wishbone Classic master modport
// Revision    : 1.0 - initial release
// ============================================================================
module up_wishbone_classic_master
    import up_wishbone_classic_master_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 4,
    parameter int TIMEOUT       = 255
) (
    input  wire logic                     clk,
    input  wire logic                     rstn,

    input  wire logic                     up_rreq,
    output logic                          up_rack,
    input  wire logic [ADDRESS_WIDTH-1:0] up_raddr,
    output logic [BUS_WIDTH*8-1:0]        up_rdata,

    input  wire logic                     up_wreq,
    output logic                          up_wack,
    input  wire logic [ADDRESS_WIDTH-1:0] up_waddr,
    input  wire logic [BUS_WIDTH*8-1:0]   up_wdata,

    output logic                          up_err,

    up_wishbone_classic_master_if.master  wb
);

    state_t                   state_q;
    logic                     cyc_q;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH*8-1:0]   wdata_q;
    logic [BUS_WIDTH*8-1:0]   rdata_q;
    logic                     rack_q;
    logic                     wack_q;
    logic                     err_q;

    logic                     w_expired;
    logic                     w_in_cycle;
    logic                     w_done;
    logic                     w_fail;

    assign w_in_cycle = (state_q == ST_READ) || (state_q == ST_WRITE);

    // Priority on termination: slave error, then slave ack, then timeout.
    assign w_done = wb.m_wb_err || wb.m_wb_ack || w_expired;
    assign w_fail = wb.m_wb_err || (!wb.m_wb_ack && w_expired);

    wb_timeout_counter #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (state_q == ST_IDLE),
        .en_i      (w_in_cycle),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rack_q  <= 1'b0;
            wack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rack_q <= 1'b0;
                    wack_q <= 1'b0;
                    err_q  <= 1'b0;
                    // Write has priority; a concurrent read stays pending
                    // (its req is still high) and is taken on the next pass.
                    if (up_wreq) begin
                        addr_q  <= up_waddr;
                        wdata_q <= up_wdata;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end else if (up_rreq) begin
                        addr_q  <= up_raddr;
                        wdata_q <= '0;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b0;
                        state_q <= ST_READ;
                    end
                end

                ST_READ, ST_WRITE: begin
                    if (w_done) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                        err_q   <= w_fail;
                        state_q <= ST_RESP;
                        if (state_q == ST_READ) begin
                            rack_q  <= 1'b1;
                            rdata_q <= w_fail ? '0 : wb.m_wb_data_i;
                        end else begin
                            wack_q  <= 1'b1;
                        end
                    end
                end

                ST_RESP: begin
                    rack_q  <= 1'b0;
                    wack_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    cyc_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign up_rack        = rack_q;
    assign up_wack        = wack_q;
    assign up_err         = err_q;
    assign up_rdata       = rdata_q;

    assign wb.m_wb_cyc    = cyc_q;
    assign wb.m_wb_stb    = cyc_q;
    assign wb.m_wb_we     = we_q;
    assign wb.m_wb_addr   = addr_q;
    assign wb.m_wb_data_o = wdata_q;
    assign wb.m_wb_sel    = {BUS_WIDTH{1'b1}};
    assign wb.m_wb_bte    = BTE_LINEAR;
    assign wb.m_wb_cti    = CTI_CLASSIC;

endmodule
`default_nettype wire
